// File: rtl/dac_cond_pkg.sv
// ============================================================================
// dac_cond_pkg : shared types/constants for the DAC setpoint conditioner. Rev 1.0
// ============================================================================
`default_nettype none

package dac_cond_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CAPTURE = 3'd1,
      S_MUL     = 3'd2,
      S_ADD     = 3'd3,
      S_SAT     = 3'd4,
      S_SLEW    = 3'd5,
      S_COMMIT  = 3'd6
   } dac_state_e;

   localparam int               GAIN_FRAC_DEFAULT = 14;
   localparam logic signed [15:0] SAT_MAX         = 16'sh7FFF;
   localparam logic signed [15:0] SAT_MIN         = 16'sh8000;
   localparam int               N_CH              = 4;

   // Zero-volt code; also the XOR mask that maps two's complement to the output domain.
   function automatic logic [15:0] zero_code(input logic offset_binary);
      return offset_binary ? 16'h8000 : 16'h0000;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dac_sat_mac.sv
// ============================================================================
// dac_sat_mac : shared one-channel multiply/round/offset/saturate datapath.
// Optional: DAC_SLEW_LIMIT_EN adds a slew stage and history.  Rev 1.0
// ============================================================================
`default_nettype none

module dac_sat_mac
   import dac_cond_pkg::*;
#(
   parameter int GAIN_FRAC = GAIN_FRAC_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            i_ch,
   input  logic                  i_mul,
   input  logic                  i_add,
   input  logic                  i_sat,
`ifdef DAC_SLEW_LIMIT_EN
   input  logic                  i_slew,
   input  logic                  i_commit,
   input  logic [15:0]           i_max_step,
`endif
   input  logic [N_CH-1:0][15:0] i_in,
   input  logic [N_CH-1:0][15:0] i_gain,
   input  logic [N_CH-1:0][15:0] i_offset,
   output logic [N_CH-1:0][15:0] o_res
);

   localparam logic signed [32:0] c_round   = 33'sd1 <<< (GAIN_FRAC - 1);
   localparam logic signed [18:0] c_acc_max = 19'(SAT_MAX);
   localparam logic signed [18:0] c_acc_min = 19'(SAT_MIN);

   logic signed [31:0]     r_prod;
   logic signed [18:0]     r_acc;
   logic [N_CH-1:0][15:0]  r_res;

   logic signed [31:0]     w_a;
   logic signed [31:0]     w_b;
   logic signed [32:0]     w_rnd;
   logic signed [18:0]     w_acc;
   logic [15:0]            w_sat;

   always_comb begin
      w_a   = 32'($signed(i_in[i_ch]));
      w_b   = 32'($signed(i_gain[i_ch]));
      w_rnd = 33'(r_prod) + c_round;
      w_acc = 19'(w_rnd >>> GAIN_FRAC) + 19'($signed(i_offset[i_ch]));
      if (r_acc > c_acc_max)
         w_sat = SAT_MAX;
      else if (r_acc < c_acc_min)
         w_sat = SAT_MIN;
      else
         w_sat = r_acc[15:0];
   end

`ifdef DAC_SLEW_LIMIT_EN
   logic [N_CH-1:0][15:0]  r_prev;
   logic signed [16:0]     w_delta;
   logic signed [16:0]     w_step;
   logic signed [16:0]     w_lim;
   logic signed [16:0]     w_slewed;

   // History lives in the two's-complement domain, independent of output encoding.
   always_comb begin
      w_delta = 17'($signed(r_res[i_ch])) - 17'($signed(r_prev[i_ch]));
      w_step  = $signed({1'b0, i_max_step});
      w_lim   = w_delta;
      if (i_max_step != 16'd0) begin
         if (w_delta > w_step)
            w_lim = w_step;
         else if (w_delta < -w_step)
            w_lim = -w_step;
      end
      w_slewed = 17'($signed(r_prev[i_ch])) + w_lim;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prod <= '0;
         r_acc  <= '0;
         r_res  <= '0;
`ifdef DAC_SLEW_LIMIT_EN
         r_prev <= '0;
`endif
      end else begin
         if (i_mul) r_prod <= w_a * w_b;
         if (i_add) r_acc  <= w_acc;
         if (i_sat) r_res[i_ch] <= w_sat;
`ifdef DAC_SLEW_LIMIT_EN
         if (i_slew)   r_res[i_ch] <= w_slewed[15:0];
         if (i_commit) r_prev      <= r_res;
`endif
      end
   end

   assign o_res = r_res;

endmodule

`default_nettype wire

// File: rtl/dac_setpoint_conditioner.sv
// ============================================================================
// dac_setpoint_conditioner : strobe-driven 4-channel gain/offset/saturate stage.
// Optional: DAC_SLEW_LIMIT_EN adds max_step port and per-channel slew limiting.  Rev 1.0
// ============================================================================
`default_nettype none

module dac_setpoint_conditioner
   import dac_cond_pkg::*;
#(
   parameter int OUT_OFFSET_BINARY = 0,
   parameter int GAIN_FRAC         = GAIN_FRAC_DEFAULT
) (
   input  logic        sysClk,
   input  logic        Reset,
   input  logic        trig,
   input  logic [15:0] in_A,
   input  logic [15:0] in_B,
   input  logic [15:0] in_C,
   input  logic [15:0] in_D,
   input  logic [15:0] gain_A,
   input  logic [15:0] gain_B,
   input  logic [15:0] gain_C,
   input  logic [15:0] gain_D,
   input  logic [15:0] offset_A,
   input  logic [15:0] offset_B,
   input  logic [15:0] offset_C,
   input  logic [15:0] offset_D,
`ifdef DAC_SLEW_LIMIT_EN
   input  logic [15:0] max_step,
`endif
   output logic [15:0] OutU16b_A,
   output logic [15:0] OutU16b_B,
   output logic [15:0] OutU16b_C,
   output logic [15:0] OutU16b_D,
   output logic        out_valid,
   output logic        busy,
   output logic [7:0]  overrun_cnt
);

   localparam logic [2:0]  ST_IDLE   = S_IDLE;
   localparam logic [2:0]  ST_MUL    = S_MUL;
   localparam logic [2:0]  ST_ADD    = S_ADD;
   localparam logic [2:0]  ST_SAT    = S_SAT;
   localparam logic [2:0]  ST_SLEW   = S_SLEW;
   localparam logic [2:0]  ST_COMMIT = S_COMMIT;
   localparam logic [15:0] c_zero    = zero_code(OUT_OFFSET_BINARY != 0);

   logic                   r_sync1, r_sync2, r_start;
   logic [2:0]             r_state;
   logic [1:0]             r_ch;
   logic [N_CH-1:0][15:0]  r_in, r_gain, r_off;
   logic [N_CH-1:0][15:0]  w_res;
   logic                   w_last;

   assign w_last = (r_ch == 2'(N_CH - 1));
   assign busy   = (r_state != ST_IDLE);

`ifdef DAC_SLEW_LIMIT_EN
   logic [15:0] r_max_step;
`endif

   dac_sat_mac #(
      .GAIN_FRAC (GAIN_FRAC)
   ) u_mac (
      .clk        (sysClk),
      .rst        (Reset),
      .i_ch       (r_ch),
      .i_mul      (r_state == ST_MUL),
      .i_add      (r_state == ST_ADD),
      .i_sat      (r_state == ST_SAT),
`ifdef DAC_SLEW_LIMIT_EN
      .i_slew     (r_state == ST_SLEW),
      .i_commit   (r_state == ST_COMMIT),
      .i_max_step (r_max_step),
`endif
      .i_in       (r_in),
      .i_gain     (r_gain),
      .i_offset   (r_off),
      .o_res      (w_res)
   );

   // The snapshot is taken on the edge that leaves IDLE, so CAPTURE costs no extra cycle.
   always_ff @(posedge sysClk) begin
      if (Reset) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_start     <= 1'b0;
         r_state     <= ST_IDLE;
         r_ch        <= 2'd0;
         r_in        <= '0;
         r_gain      <= '0;
         r_off       <= '0;
         OutU16b_A   <= c_zero;
         OutU16b_B   <= c_zero;
         OutU16b_C   <= c_zero;
         OutU16b_D   <= c_zero;
         out_valid   <= 1'b0;
         overrun_cnt <= 8'd0;
`ifdef DAC_SLEW_LIMIT_EN
         r_max_step  <= 16'd0;
`endif
      end else begin
         r_sync1   <= trig;
         r_sync2   <= r_sync1;
         r_start   <= r_sync1 & ~r_sync2;
         out_valid <= 1'b0;
         if (r_start && (r_state != ST_IDLE) && (overrun_cnt != 8'hFF))
            overrun_cnt <= overrun_cnt + 8'd1;
         case (r_state)
            ST_IDLE: begin
               if (r_start) begin
                  r_in    <= {in_D, in_C, in_B, in_A};
                  r_gain  <= {gain_D, gain_C, gain_B, gain_A};
                  r_off   <= {offset_D, offset_C, offset_B, offset_A};
`ifdef DAC_SLEW_LIMIT_EN
                  r_max_step <= max_step;
`endif
                  r_ch    <= 2'd0;
                  r_state <= ST_MUL;
               end
            end
            ST_MUL: r_state <= ST_ADD;
            ST_ADD: r_state <= ST_SAT;
`ifdef DAC_SLEW_LIMIT_EN
            ST_SAT: r_state <= ST_SLEW;
            ST_SLEW: begin
`else
            ST_SAT: begin
`endif
               r_ch    <= w_last ? r_ch : r_ch + 2'd1;
               r_state <= w_last ? ST_COMMIT : ST_MUL;
            end
            ST_COMMIT: begin
               OutU16b_A <= w_res[0] ^ c_zero;
               OutU16b_B <= w_res[1] ^ c_zero;
               OutU16b_C <= w_res[2] ^ c_zero;
               OutU16b_D <= w_res[3] ^ c_zero;
               out_valid <= 1'b1;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dac_setpoint_conditioner.sv
// ============================================================================
// tb_dac_setpoint_conditioner : directed-vector bench, two's-complement and offset-binary DUTs.
// Optional: DAC_SLEW_LIMIT_EN enables the slew sequences.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_dac_setpoint_conditioner;

   logic sysClk = 1'b0;
   always #5 sysClk = ~sysClk;

   logic        Reset, trig;
   logic [15:0] in_A, in_B, in_C, in_D;
   logic [15:0] gain_A, gain_B, gain_C, gain_D;
   logic [15:0] offset_A, offset_B, offset_C, offset_D;
`ifdef DAC_SLEW_LIMIT_EN
   logic [15:0] max_step;
   localparam int LAT = 19;
`else
   localparam int LAT = 15;
`endif

   logic [3:0][15:0] o0, o1;
   logic             vld0, vld1, busy0, busy1;
   logic [7:0]       ovr0, ovr1;

   dac_setpoint_conditioner #(.OUT_OFFSET_BINARY(0)) dut0 (
      .sysClk(sysClk), .Reset(Reset), .trig(trig),
      .in_A(in_A), .in_B(in_B), .in_C(in_C), .in_D(in_D),
      .gain_A(gain_A), .gain_B(gain_B), .gain_C(gain_C), .gain_D(gain_D),
      .offset_A(offset_A), .offset_B(offset_B), .offset_C(offset_C), .offset_D(offset_D),
`ifdef DAC_SLEW_LIMIT_EN
      .max_step(max_step),
`endif
      .OutU16b_A(o0[0]), .OutU16b_B(o0[1]), .OutU16b_C(o0[2]), .OutU16b_D(o0[3]),
      .out_valid(vld0), .busy(busy0), .overrun_cnt(ovr0)
   );

   dac_setpoint_conditioner #(.OUT_OFFSET_BINARY(1)) dut1 (
      .sysClk(sysClk), .Reset(Reset), .trig(trig),
      .in_A(in_A), .in_B(in_B), .in_C(in_C), .in_D(in_D),
      .gain_A(gain_A), .gain_B(gain_B), .gain_C(gain_C), .gain_D(gain_D),
      .offset_A(offset_A), .offset_B(offset_B), .offset_C(offset_C), .offset_D(offset_D),
`ifdef DAC_SLEW_LIMIT_EN
      .max_step(max_step),
`endif
      .OutU16b_A(o1[0]), .OutU16b_B(o1[1]), .OutU16b_C(o1[2]), .OutU16b_D(o1[3]),
      .out_valid(vld1), .busy(busy1), .overrun_cnt(ovr1)
   );

   typedef struct {
      logic [3:0][15:0] in;
      logic [3:0][15:0] gain;
      logic [3:0][15:0] off;
      logic [3:0][15:0] exp;
   } vec_t;

   vec_t vecs[3];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [3:0][15:0] req);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("%s_tc_ch%0d", tag, c), o0[c], req[c]);
         chk($sformatf("%s_ob_ch%0d", tag, c), o1[c], req[c] ^ 16'h8000);
      end
   endtask

   task automatic set_inputs(input vec_t v);
      in_A = v.in[0];       in_B = v.in[1];       in_C = v.in[2];       in_D = v.in[3];
      gain_A = v.gain[0];   gain_B = v.gain[1];   gain_C = v.gain[2];   gain_D = v.gain[3];
      offset_A = v.off[0];  offset_B = v.off[1];  offset_C = v.off[2];  offset_D = v.off[3];
   endtask

   task automatic do_reset();
      @(negedge sysClk); Reset = 1'b1;
      repeat (3) @(negedge sysClk);
      Reset = 1'b0;
   endtask

   // Edge e=0 is the first edge that samples trig high; records first out_valid edge and pulse count.
   task automatic run_frame(output int lat, output int pulses, output logic b1, output logic b2,
                            output logic bend);
      lat = -1; pulses = 0; b1 = 1'bx; b2 = 1'bx; bend = 1'bx;
      @(negedge sysClk); trig = 1'b1;
      for (int e = 0; e < LAT + 6; e++) begin
         @(posedge sysClk); #1;
         if (e == 2) trig = 1'b0;
         if (e == 1) b1 = busy0;
         if (e == 2) b2 = busy0;
         if (e == LAT) bend = busy0;
         if (vld0) begin
            pulses++;
            if (lat < 0) lat = e;
         end
      end
   endtask

   int   lat, pulses;
   logic b1, b2, bend;

   initial begin
      vecs[0].in   = {16'h0001, 16'h8000, 16'h7FFF, 16'h1234};
      vecs[0].gain = {16'h2000, 16'h4000, 16'h7FFF, 16'h4000};
      vecs[0].off  = {16'h0000, 16'h8000, 16'h1000, 16'h0000};
      vecs[0].exp  = {16'h0001, 16'h8000, 16'h7FFF, 16'h1234};
      vecs[1].in   = {16'hFFFF, 16'h0000, 16'h1000, 16'h0100};
      vecs[1].gain = {16'h2000, 16'h4000, 16'h2000, 16'h8000};
      vecs[1].off  = {16'h0000, 16'hFFF6, 16'h0005, 16'h0000};
      vecs[1].exp  = {16'h0000, 16'hFFF6, 16'h0805, 16'hFE00};
      vecs[2].in   = {16'h0003, 16'hFFFD, 16'h7FFF, 16'h8000};
      vecs[2].gain = {16'h2000, 16'h6000, 16'h4000, 16'h8000};
      vecs[2].off  = {16'h0000, 16'h0000, 16'h0001, 16'h0000};
      vecs[2].exp  = {16'h0002, 16'hFFFC, 16'h7FFF, 16'h7FFF};

      Reset = 1'b0; trig = 1'b0;
      set_inputs(vecs[0]);
`ifdef DAC_SLEW_LIMIT_EN
      max_step = 16'h0000;
`endif
      do_reset();
      @(posedge sysClk); #1;
      chk_outs("reset", '0);
      chk("reset_valid", {15'd0, vld0}, 16'd0);
      chk("reset_busy", {15'd0, busy0}, 16'd0);
      chk("reset_overrun", {8'd0, ovr0}, 16'd0);

      for (int i = 0; i < 3; i++) begin
         set_inputs(vecs[i]);
         run_frame(lat, pulses, b1, b2, bend);
         chk($sformatf("v%0d_latency", i), 16'(lat), 16'(LAT));
         chk($sformatf("v%0d_pulses", i), 16'(pulses), 16'd1);
         chk($sformatf("v%0d_busy_k1", i), {15'd0, b1}, 16'd0);
         chk($sformatf("v%0d_busy_k2", i), {15'd0, b2}, 16'd1);
         chk($sformatf("v%0d_busy_end", i), {15'd0, bend}, 16'd0);
         chk_outs($sformatf("v%0d", i), vecs[i].exp);
         chk($sformatf("v%0d_overrun", i), {8'd0, ovr0}, 16'd0);
      end

      // Overrun: second rising edge sampled at k+5, inputs changed after the snapshot.
      set_inputs(vecs[0]);
      pulses = 0;
      @(negedge sysClk); trig = 1'b1;
      for (int e = 0; e < 40; e++) begin
         @(posedge sysClk); #1;
         if (e == 1) trig = 1'b0;
         if (e == 3) set_inputs(vecs[1]);
         if (e == 4) trig = 1'b1;
         if (e == 6) trig = 1'b0;
         if (vld0) pulses++;
      end
      chk("ovr_pulses", 16'(pulses), 16'd1);
      chk("ovr_count_tc", {8'd0, ovr0}, 16'd1);
      chk("ovr_count_ob", {8'd0, ovr1}, 16'd1);
      chk_outs("ovr", vecs[0].exp);

      // Reset sampled at edge k+8 aborts the frame.
      set_inputs(vecs[2]);
      pulses = 0;
      @(negedge sysClk); trig = 1'b1;
      for (int e = 0; e < 30; e++) begin
         @(posedge sysClk); #1;
         if (e == 1) trig = 1'b0;
         if (e == 7) Reset = 1'b1;
         if (e == 8) begin
            Reset = 1'b0;
            chk("midrst_busy", {15'd0, busy0}, 16'd0);
         end
         if (vld0 || vld1) pulses++;
      end
      chk("midrst_pulses", 16'(pulses), 16'd0);
      chk("midrst_overrun", {8'd0, ovr0}, 16'd0);
      chk_outs("midrst", '0);

`ifdef DAC_SLEW_LIMIT_EN
      in_A = 16'h1000; gain_A = 16'h4000; offset_A = 16'h0000;
      in_B = 16'h0000; in_C = 16'h0000; in_D = 16'h0000;
      offset_B = 16'h0000; offset_C = 16'h0000; offset_D = 16'h0000;
      max_step = 16'h0100;
      do_reset();
      for (int n = 1; n <= 17; n++) begin
         run_frame(lat, pulses, b1, b2, bend);
         chk($sformatf("slew_step%0d", n), o0[0], (n > 16) ? 16'h1000 : 16'(n * 256));
         chk($sformatf("slew_step%0d_ob", n), o1[0],
             ((n > 16) ? 16'h1000 : 16'(n * 256)) ^ 16'h8000);
      end
      max_step = 16'h0000;
      do_reset();
      run_frame(lat, pulses, b1, b2, bend);
      chk("slew_off_first", o0[0], 16'h1000);
      chk("slew_off_first_ob", o1[0], 16'h9000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
